control_unit: RTL and testbench

- Hardwired control sequencer that sits directly upstream of `datapath` and drives its register-transfer control inputs.
- Fetches each instruction over steps T0–T2, then decodes IR[31:27] and issues the execute micro-steps (T3–T7) for the instruction class.
- Replaces the hand-scripted control sequences currently driven by benches.
- Register selection is done by the datapath's select-and-encode logic using the Gra/Grb/Grc, Rin, Rout and BAout outputs.

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/control_unit_decode.sv | 38 +++
 rtl/control_unit.sv | 148 ++++++++++++++
 tb/tb_control_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-code, sequencer-step and control-word definitions for the CPU control path.
package cpu_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned STEP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010, OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100, OP_AND  = 5'b00101, OP_OR   = 5'b00110, OP_ROL  = 5'b00111,
    OP_ROR  = 5'b01000, OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011,
    OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110, OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000, OP_NEG  = 5'b10001, OP_NOT  = 5'b10010, OP_NOP  = 5'b11010,
    OP_HALT = 5'b11011
  } op_e;

  // ALU operation codes; rotate codes are swapped relative to the instruction opcodes.
  localparam logic [OP_W-1:0] ALU_NONE = 5'b00000;
  localparam logic [OP_W-1:0] ALU_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] ALU_AND  = 5'b00101;
  localparam logic [OP_W-1:0] ALU_OR   = 5'b00110;
  localparam logic [OP_W-1:0] ALU_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] ALU_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] ALU_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] ALU_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] ALU_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] ALU_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] ALU_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] ALU_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] ALU_NOT  = 5'b10010;

  typedef enum logic [STEP_W-1:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    HALT = 4'd15
  } step_e;

  typedef enum logic [3:0] {
    CL_R, CL_IMM, CL_UNARY, CL_MULDIV, CL_LDI, CL_LD, CL_ST, CL_NOP, CL_HALT
  } iclass_e;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc, mar_in, z_in, z_low_out, z_high_out, read, write;
    logic mdr_in, mdr_out, ir_in, y_in, c_out, hi_in, lo_in;
    logic gra, grb, grc, r_in, r_out, ba_out;
    logic [OP_W-1:0] opcode;
  } ctrl_t;

  // Final T-step of each instruction class; the instruction boundary.
  function automatic step_e last_step(input iclass_e cl);
    case (cl)
      CL_R, CL_IMM, CL_LDI: last_step = T5;
      CL_UNARY:             last_step = T4;
      CL_MULDIV:            last_step = T6;
      CL_LD, CL_ST:         last_step = T7;
      default:              last_step = T2;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Opcode decoder: instruction class and ALU operation for the current IR opcode.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] ir_op,
  output iclass_e         iclass_c,
  output logic [OP_W-1:0] alu_op_c
);

  always_comb begin
    iclass_c = CL_NOP;
    alu_op_c = ALU_NONE;
    case (op_e'(ir_op))
      OP_ADD:  begin iclass_c = CL_R;      alu_op_c = ALU_ADD;  end
      OP_SUB:  begin iclass_c = CL_R;      alu_op_c = ALU_SUB;  end
      OP_AND:  begin iclass_c = CL_R;      alu_op_c = ALU_AND;  end
      OP_OR:   begin iclass_c = CL_R;      alu_op_c = ALU_OR;   end
      OP_ROL:  begin iclass_c = CL_R;      alu_op_c = ALU_ROL;  end
      OP_ROR:  begin iclass_c = CL_R;      alu_op_c = ALU_ROR;  end
      OP_SHR:  begin iclass_c = CL_R;      alu_op_c = ALU_SHR;  end
      OP_SHRA: begin iclass_c = CL_R;      alu_op_c = ALU_SHRA; end
      OP_SHL:  begin iclass_c = CL_R;      alu_op_c = ALU_SHL;  end
      OP_ADDI: begin iclass_c = CL_IMM;    alu_op_c = ALU_ADD;  end
      OP_ANDI: begin iclass_c = CL_IMM;    alu_op_c = ALU_AND;  end
      OP_ORI:  begin iclass_c = CL_IMM;    alu_op_c = ALU_OR;   end
      OP_NEG:  begin iclass_c = CL_UNARY;  alu_op_c = ALU_NEG;  end
      OP_NOT:  begin iclass_c = CL_UNARY;  alu_op_c = ALU_NOT;  end
      OP_MUL:  begin iclass_c = CL_MULDIV; alu_op_c = ALU_MUL;  end
      OP_DIV:  begin iclass_c = CL_MULDIV; alu_op_c = ALU_DIV;  end
      OP_LDI:  begin iclass_c = CL_LDI;    alu_op_c = ALU_ADD;  end
      OP_LD:   begin iclass_c = CL_LD;     alu_op_c = ALU_ADD;  end
      OP_ST:   begin iclass_c = CL_ST;     alu_op_c = ALU_ADD;  end
      OP_HALT: iclass_c = CL_HALT;
      default: iclass_c = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer driving the datapath register-transfer controls.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = OP_W
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [OPW-1:0] ir_op,
  input  logic           stop,
  output logic           run,
  output logic [3:0]     step,
  output logic           PCout,
  output logic           PCin,
  output logic           incPC,
  output logic           MARin,
  output logic           Zin,
  output logic           ZLowOut,
  output logic           ZHighOut,
  output logic           Read,
  output logic           Write,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           Cout,
  output logic           HIin,
  output logic           LOin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic [OPW-1:0] opcode
);

  step_e           state, state_nxt;
  logic            stop_req;
  iclass_e         iclass_c;
  logic [OP_W-1:0] alu_c;
  ctrl_t           ctl_c;

  ctrl_decode u_decode (
    .ir_op    (OP_W'(ir_op)),
    .iclass_c (iclass_c),
    .alu_op_c (alu_c)
  );

  // Advance one step per cycle; at the class's last step return to T0 or halt.
  always_comb begin
    state_nxt = state;
    if (state != HALT) begin
      if (state >= last_step(iclass_c)) begin
        state_nxt = (iclass_c == CL_HALT || stop || stop_req) ? HALT : T0;
      end else begin
        state_nxt = step_e'(state + STEP_W'(1));
      end
    end
  end

  // A stop request is remembered until the next instruction boundary.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= T0;
      stop_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      stop_req <= stop_req | stop;
    end
  end

  // Control word decode; everything is held at zero while clr is low.
  always_comb begin
    ctl_c = '0;
    if (clr) begin
      case (state)
        T0: begin ctl_c.pc_out = 1'b1; ctl_c.mar_in = 1'b1; ctl_c.inc_pc = 1'b1; ctl_c.z_in = 1'b1; end
        T1: begin ctl_c.z_low_out = 1'b1; ctl_c.pc_in = 1'b1; ctl_c.read = 1'b1; ctl_c.mdr_in = 1'b1; end
        T2: begin ctl_c.mdr_out = 1'b1; ctl_c.ir_in = 1'b1; end
        T3: case (iclass_c)
          CL_R, CL_IMM: begin ctl_c.grb = 1'b1; ctl_c.r_out = 1'b1; ctl_c.y_in = 1'b1; end
          CL_UNARY: begin
            ctl_c.grb = 1'b1; ctl_c.r_out = 1'b1; ctl_c.z_in = 1'b1; ctl_c.opcode = alu_c;
          end
          CL_MULDIV: begin ctl_c.gra = 1'b1; ctl_c.r_out = 1'b1; ctl_c.y_in = 1'b1; end
          CL_LDI, CL_LD, CL_ST: begin ctl_c.grb = 1'b1; ctl_c.ba_out = 1'b1; ctl_c.y_in = 1'b1; end
          default: ;
        endcase
        T4: case (iclass_c)
          CL_R, CL_MULDIV: begin
            ctl_c.grc = (iclass_c == CL_R); ctl_c.grb = (iclass_c == CL_MULDIV);
            ctl_c.r_out = 1'b1; ctl_c.z_in = 1'b1; ctl_c.opcode = alu_c;
          end
          CL_IMM: begin ctl_c.c_out = 1'b1; ctl_c.z_in = 1'b1; ctl_c.opcode = alu_c; end
          CL_UNARY: begin ctl_c.z_low_out = 1'b1; ctl_c.gra = 1'b1; ctl_c.r_in = 1'b1; end
          CL_LDI, CL_LD, CL_ST: begin ctl_c.c_out = 1'b1; ctl_c.z_in = 1'b1; ctl_c.opcode = ALU_ADD; end
          default: ;
        endcase
        T5: case (iclass_c)
          CL_R, CL_IMM, CL_LDI: begin ctl_c.z_low_out = 1'b1; ctl_c.gra = 1'b1; ctl_c.r_in = 1'b1; end
          CL_MULDIV: begin ctl_c.z_low_out = 1'b1; ctl_c.lo_in = 1'b1; end
          CL_LD, CL_ST: begin ctl_c.z_low_out = 1'b1; ctl_c.mar_in = 1'b1; end
          default: ;
        endcase
        T6: case (iclass_c)
          CL_MULDIV: begin ctl_c.z_high_out = 1'b1; ctl_c.hi_in = 1'b1; end
          CL_LD: begin ctl_c.read = 1'b1; ctl_c.mdr_in = 1'b1; end
          CL_ST: begin ctl_c.gra = 1'b1; ctl_c.r_out = 1'b1; ctl_c.mdr_in = 1'b1; end
          default: ;
        endcase
        T7: case (iclass_c)
          CL_LD: begin ctl_c.mdr_out = 1'b1; ctl_c.gra = 1'b1; ctl_c.r_in = 1'b1; end
          CL_ST: ctl_c.write = 1'b1;
          default: ;
        endcase
        default: ;
      endcase
    end
  end

  assign run      = (state != HALT);
  assign step     = 4'(state);
  assign PCout    = ctl_c.pc_out;
  assign PCin     = ctl_c.pc_in;
  assign incPC    = ctl_c.inc_pc;
  assign MARin    = ctl_c.mar_in;
  assign Zin      = ctl_c.z_in;
  assign ZLowOut  = ctl_c.z_low_out;
  assign ZHighOut = ctl_c.z_high_out;
  assign Read     = ctl_c.read;
  assign Write    = ctl_c.write;
  assign MDRin    = ctl_c.mdr_in;
  assign MDRout   = ctl_c.mdr_out;
  assign IRin     = ctl_c.ir_in;
  assign Yin      = ctl_c.y_in;
  assign Cout     = ctl_c.c_out;
  assign HIin     = ctl_c.hi_in;
  assign LOin     = ctl_c.lo_in;
  assign Gra      = ctl_c.gra;
  assign Grb      = ctl_c.grb;
  assign Grc      = ctl_c.grc;
  assign Rin      = ctl_c.r_in;
  assign Rout     = ctl_c.r_out;
  assign BAout    = ctl_c.ba_out;
  assign opcode   = OPW'(ctl_c.opcode);

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against a per-instruction expected-cycle queue model.
module tb_control_unit;

  localparam int PCOUT = 0, PCIN = 1, INCPC = 2, MARIN = 3, ZIN = 4, ZLO = 5, ZHI = 6,
                 READ = 7, WRITE = 8, MDRIN = 9, MDROUT = 10, IRIN = 11, YIN = 12,
                 COUT = 13, HIIN = 14, LOIN = 15, GRA = 16, GRB = 17, GRC = 18,
                 RIN = 19, ROUT = 20, BAOUT = 21;
  localparam logic [31:0] RUN_M    = 32'h8000_0000;
  localparam logic [31:0] STEP_M   = 32'h7800_0000;
  localparam logic [31:0] OPC_M    = 32'h07C0_0000;
  localparam logic [31:0] RST_VEC  = 32'h8000_0000;
  localparam logic [31:0] HALT_VEC = 32'h7800_0000;
  localparam logic [4:0] I_LD = 5'd0, I_ST = 5'd2, I_ADD = 5'd3, I_ROR = 5'd8,
                         I_ADDI = 5'd12, I_MUL = 5'd15, I_NOP = 5'd26, I_HALT = 5'd27;

  logic clk, clr, stop, run;
  logic [4:0] ir_op, opcode;
  logic [3:0] step;
  logic PCout, PCin, incPC, MARin, Zin, ZLowOut, ZHighOut, Read, Write, MDRin, MDRout;
  logic IRin, Yin, Cout, HIin, LOin, Gra, Grb, Grc, Rin, Rout, BAout;

  control_unit #(.OPW(5)) dut (
    .clk(clk), .clr(clr), .ir_op(ir_op), .stop(stop), .run(run), .step(step),
    .PCout(PCout), .PCin(PCin), .incPC(incPC), .MARin(MARin), .Zin(Zin),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .Read(Read), .Write(Write),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Cout(Cout),
    .HIin(HIin), .LOin(LOin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .opcode(opcode)
  );

  wire [31:0] act = {run, step, opcode, BAout, Rout, Rin, Grc, Grb, Gra, LOin, HIin, Cout,
                     Yin, IRin, MDRout, MDRin, Write, Read, ZHighOut, ZLowOut, Zin, MARin,
                     incPC, PCin, PCout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] q[$];
  logic [4:0]  plan[$];
  logic [31:0] exp_vec, lit_m, lit_v;
  string       lit_name;
  bit          exp_valid, lit_valid, tmo, halted, pending, started, use_rand;
  logic [4:0]  cur_op;
  int          n_cmp, n_bad, stop_prob, halt_pct;

  function automatic logic [31:0] b(input int i);
    return 32'(1) << i;
  endfunction

  function automatic logic [31:0] mk(input int t, input logic [31:0] c, input logic [4:0] a);
    return RUN_M | (32'(t) << 27) | (32'(a) << 22) | c;
  endfunction

  function automatic logic [4:0] alu_of(input logic [4:0] op);
    case (op)
      5'd7:  return 5'd8;
      5'd8:  return 5'd7;
      5'd12: return 5'd3;
      5'd13: return 5'd5;
      5'd14: return 5'd6;
      default: return op;
    endcase
  endfunction

  function automatic logic [4:0] rand_op();
    int unsigned r;
    r = $urandom_range(0, 31);
    if ($urandom_range(0, 99) < halt_pct) return I_HALT;
    if (r == 27) r = 26;
    return 5'(r);
  endfunction

  // Expected cycle-by-cycle control words for one whole instruction.
  task automatic build_seq(input logic [4:0] op);
    logic [4:0] a;
    a = alu_of(op);
    q.push_back(mk(0, b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN), 5'd0));
    q.push_back(mk(1, b(ZLO) | b(PCIN) | b(READ) | b(MDRIN), 5'd0));
    q.push_back(mk(2, b(MDROUT) | b(IRIN), 5'd0));
    if (op >= 5'd3 && op <= 5'd11) begin
      q.push_back(mk(3, b(GRB) | b(ROUT) | b(YIN), 5'd0));
      q.push_back(mk(4, b(GRC) | b(ROUT) | b(ZIN), a));
      q.push_back(mk(5, b(ZLO) | b(GRA) | b(RIN), 5'd0));
    end else if (op >= 5'd12 && op <= 5'd14) begin
      q.push_back(mk(3, b(GRB) | b(ROUT) | b(YIN), 5'd0));
      q.push_back(mk(4, b(COUT) | b(ZIN), a));
      q.push_back(mk(5, b(ZLO) | b(GRA) | b(RIN), 5'd0));
    end else if (op == 5'd17 || op == 5'd18) begin
      q.push_back(mk(3, b(GRB) | b(ROUT) | b(ZIN), a));
      q.push_back(mk(4, b(ZLO) | b(GRA) | b(RIN), 5'd0));
    end else if (op == 5'd15 || op == 5'd16) begin
      q.push_back(mk(3, b(GRA) | b(ROUT) | b(YIN), 5'd0));
      q.push_back(mk(4, b(GRB) | b(ROUT) | b(ZIN), a));
      q.push_back(mk(5, b(ZLO) | b(LOIN), 5'd0));
      q.push_back(mk(6, b(ZHI) | b(HIIN), 5'd0));
    end else if (op <= 5'd2) begin
      q.push_back(mk(3, b(GRB) | b(BAOUT) | b(YIN), 5'd0));
      q.push_back(mk(4, b(COUT) | b(ZIN), 5'd3));
      if (op == 5'd1) begin
        q.push_back(mk(5, b(ZLO) | b(GRA) | b(RIN), 5'd0));
      end else begin
        q.push_back(mk(5, b(ZLO) | b(MARIN), 5'd0));
        if (op == 5'd0) begin
          q.push_back(mk(6, b(READ) | b(MDRIN), 5'd0));
          q.push_back(mk(7, b(MDROUT) | b(GRA) | b(RIN), 5'd0));
        end else begin
          q.push_back(mk(6, b(GRA) | b(ROUT) | b(MDRIN), 5'd0));
          q.push_back(mk(7, b(WRITE), 5'd0));
        end
      end
    end
  endtask

  task automatic start_next();
    logic [4:0] op;
    if (!halted && started && (cur_op == I_HALT || pending)) halted = 1'b1;
    if (halted) begin
      q.push_back(HALT_VEC);
      return;
    end
    if (plan.size() > 0) op = plan.pop_front();
    else op = use_rand ? rand_op() : I_NOP;
    cur_op = op;
    ir_op = op;
    started = 1'b1;
    build_seq(op);
  endtask

  task automatic tick_model();
    lit_valid = 1'b0;
    tmo = 1'b0;
    if (q.size() == 0) start_next();
    exp_vec = q.pop_front();
    exp_valid = 1'b1;
    stop = ($urandom_range(0, 999) < stop_prob);
    if (stop) pending = 1'b1;
  endtask

  task automatic lit(input string n, input logic [31:0] m, input logic [31:0] v);
    lit_name = n; lit_m = m; lit_v = v; lit_valid = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    tick_model();
  endtask

  task automatic run_until(input logic [3:0] s);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 24 && !hit; i++) begin
      cyc();
      hit = (exp_vec[30:27] == s);
    end
    if (!hit) tmo = 1'b1;
  endtask

  task automatic do_reset(input int hold);
    clr = 1'b0;
    stop = 1'b0;
    tmo = 1'b0;
    exp_vec = RST_VEC;
    exp_valid = 1'b1;
    lit("rst_zero", 32'hFFFF_FFFF, RST_VEC);
    repeat (hold) @(posedge clk);
    #1;
    clr = 1'b1;
    q.delete();
    halted = 1'b0; pending = 1'b0; started = 1'b0;
    tick_model();
    lit("rst_t0", RUN_M | STEP_M | b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN),
        RUN_M | b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN));
  endtask

  // Single compare process: model word, structural exclusivity, literal pins, timeouts.
  always @(negedge clk) begin
    if (exp_valid) begin
      n_cmp++;
      if (act !== exp_vec) begin
        n_bad++;
        $display("FAIL seq t=%0t: got %h want %h", $time, act, exp_vec);
      end
      n_cmp++;
      if ($countones({Gra, Grb, Grc}) > 1 || (Read && Write) ||
          $countones({PCout, ZLowOut, ZHighOut, MDRout, Rout, Cout, BAout}) > 1) begin
        n_bad++;
        $display("FAIL excl t=%0t: got %h want <=1 select, <=1 driver, not Read&Write", $time, act);
      end
    end
    if (lit_valid) begin
      n_cmp++;
      if ((act & lit_m) !== lit_v) begin
        n_bad++;
        $display("FAIL %s t=%0t: got %h want %h", lit_name, $time, act & lit_m, lit_v);
      end
    end
    if (tmo) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout t=%0t: got no target step want target step", $time);
    end
  end

  initial begin
    clr = 1'b0; stop = 1'b0; ir_op = 5'd0; exp_vec = RST_VEC; lit_m = '0; lit_v = '0;
    exp_valid = 1'b0; lit_valid = 1'b0; tmo = 1'b0; halted = 1'b0; pending = 1'b0;
    started = 1'b0; use_rand = 1'b0; cur_op = 5'd0; n_cmp = 0; n_bad = 0;
    stop_prob = 0; halt_pct = 0; lit_name = "";

    plan.push_back(I_ADD);
    do_reset(2);
    run_until(4'd4);
    plan.push_back(I_ROR); plan.push_back(I_ROR); plan.push_back(I_LD);
    plan.push_back(I_ST);  plan.push_back(I_MUL); plan.push_back(I_HALT);
    do_reset(1);

    run_until(4'd4);
    lit("ror_t4", OPC_M | b(GRC) | b(ROUT) | b(ZIN), (32'(5'b00111) << 22) | b(GRC) | b(ROUT) | b(ZIN));
    cyc();
    lit("ror_t5", b(ZLO) | b(GRA) | b(RIN), b(ZLO) | b(GRA) | b(RIN));
    run_until(4'd6);
    lit("ld_t6", b(READ) | b(MDRIN) | b(WRITE), b(READ) | b(MDRIN));
    cyc();
    lit("ld_t7", b(MDROUT) | b(GRA) | b(RIN) | b(WRITE), b(MDROUT) | b(GRA) | b(RIN));
    run_until(4'd6);
    lit("st_t6", b(READ) | b(MDRIN), b(MDRIN));
    cyc();
    lit("st_t7", b(READ) | b(WRITE), b(WRITE));
    run_until(4'd5);
    lit("mul_t5", b(LOIN) | b(HIIN), b(LOIN));
    cyc();
    lit("mul_t6", b(LOIN) | b(HIIN), b(HIIN));
    cyc();
    lit("mul_next", RUN_M | STEP_M, RUN_M);
    run_until(4'd15);
    repeat (50) cyc();
    lit("halt_hold", RUN_M | STEP_M, HALT_VEC);

    plan.push_back(I_ADDI);
    do_reset(1);
    run_until(4'd3);
    stop = 1'b1;
    pending = 1'b1;
    run_until(4'd5);
    cyc();
    lit("stop_halt", RUN_M | STEP_M, HALT_VEC);

    use_rand = 1'b1;
    stop_prob = 5;
    halt_pct = 2;
    for (int ep = 0; ep < 12; ep++) begin
      @(posedge clk);
      #1;
      do_reset(1 + int'($urandom_range(0, 1)));
      repeat (300) begin
        @(posedge clk);
        #1;
        if ($urandom_range(0, 299) == 0) do_reset(1);
        else tick_model();
      end
    end

    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    lit_valid = 1'b0;
    tmo = 1'b0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
